div_iter: RTL and testbench

DIV_ITER -- requirements
Module: div_iter

---
 rtl/div_iter_pkg.sv | 22 ++
 rtl/div_step.sv | 22 ++
 rtl/div_iter.sv | 113 +++++++++++
 tb/tb_div_iter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: FSM encoding,
// iteration count, the divide-by-zero quotient and a magnitude helper.
package div_iter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int          DIV_ITER_CNT = 32;
    localparam logic [31:0] DIV0_QUO     = 32'hFFFF_FFFF;

    // Absolute value formed in 33 bits so that 0x80000000 maps to 2^31;
    // with s=0 the operand is taken as unsigned and passed through.
    function automatic logic [31:0] mag32(input logic [31:0] x, input logic s);
        logic [32:0] t;
        t = (s && x[31]) ? (33'd0 - {x[31], x}) : {1'b0, x};
        return 32'(t);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step on unsigned magnitudes:
// shifts the next dividend bit into the partial remainder and subtracts
// the divisor when it fits, producing one quotient bit.
module div_step (
    input  logic [31:0] i_rem,
    input  logic        i_bit,
    input  logic [31:0] i_div,
    output logic [31:0] o_rem,
    output logic        o_qbit
);

    logic [32:0] w_sh;
    logic [31:0] w_diff;

    assign w_sh   = {i_rem, i_bit};
    // The partial remainder stays below the divisor, so the low 32 bits
    // of the difference are exact whenever the subtraction is taken.
    assign w_diff = w_sh[31:0] - i_div;
    assign o_qbit = (w_sh >= {1'b0, i_div});
    assign o_rem  = o_qbit ? w_diff : w_sh[31:0];

endmodule

// File: rtl/div_iter.sv
// Iterative 32-bit signed/unsigned divider, one quotient bit per cycle.
// Operands are latched on start; magnitudes are divided and the signs
// fixed up combinationally in DONE. quo/rem hold the last valid result.
module div_iter
    import div_iter_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        sign,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        annul,
    output logic        busy,
    output logic        valid,
    output logic [31:0] quo,
    output logic [31:0] rem,
    output logic        stall
);

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [31:0] r_a;        // raw dividend, returned as remainder on b==0
    logic [31:0] r_bmag;     // divisor magnitude
    logic [31:0] r_dvd;      // dividend magnitude, shifts out; quotient shifts in
    logic [31:0] r_prem;     // partial remainder magnitude
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_div0;
    logic [31:0] r_quo_out;
    logic [31:0] r_rem_out;

    logic [31:0] w_nrem;
    logic        w_qbit;
    logic        w_valid;
    logic [31:0] w_fin_quo;
    logic [31:0] w_fin_rem;

    div_step u_step (
        .i_rem  (r_prem),
        .i_bit  (r_dvd[31]),
        .i_div  (r_bmag),
        .o_rem  (w_nrem),
        .o_qbit (w_qbit)
    );

    assign w_fin_quo = r_div0  ? DIV0_QUO :
                       r_neg_q ? (32'd0 - r_dvd) : r_dvd;
    assign w_fin_rem = r_div0  ? r_a :
                       r_neg_r ? (32'd0 - r_prem) : r_prem;

    // A flush in the DONE cycle must kill that cycle's pulse, so valid
    // is qualified combinationally by annul.
    assign w_valid = (r_state == ST_DONE) && !annul;
    assign valid   = w_valid;
    assign busy    = (r_state != ST_IDLE);
    assign quo     = w_valid ? w_fin_quo : r_quo_out;
    assign rem     = w_valid ? w_fin_rem : r_rem_out;
    assign stall   = (start && (r_state == ST_IDLE) && !annul) || (busy && !w_valid);

    // Control FSM plus operand/working registers; annul overrides everything.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_a       <= '0;
            r_bmag    <= '0;
            r_dvd     <= '0;
            r_prem    <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_div0    <= 1'b0;
            r_quo_out <= '0;
            r_rem_out <= '0;
        end else if (annul) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_bmag  <= mag32(b, sign);
                        r_dvd   <= mag32(a, sign);
                        r_prem  <= '0;
                        r_cnt   <= '0;
                        r_neg_q <= sign && (a[31] != b[31]);
                        r_neg_r <= sign && a[31];
                        r_div0  <= (b == 32'd0);
                        r_state <= (b == 32'd0) ? ST_DONE : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_prem <= w_nrem;
                    r_dvd  <= {r_dvd[30:0], w_qbit};
                    if (r_cnt == 6'(DIV_ITER_CNT - 1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                ST_DONE: begin
                    r_quo_out <= w_fin_quo;
                    r_rem_out <= w_fin_rem;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: a vector table of divides run back to
// back, plus hand sequences for annul, annul+start, annul in DONE and
// asynchronous reset mid-operation.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic        annul;
    logic        busy;
    logic        valid;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        stall;

    int checks   = 0;
    int failures = 0;
    logic [31:0] last_q = '0;
    logic [31:0] last_r = '0;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vec [12];

    div_iter dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .sign   (sign),
        .a      (a),
        .b      (b),
        .annul  (annul),
        .busy   (busy),
        .valid  (valid),
        .quo    (quo),
        .rem    (rem),
        .stall  (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; leaves off at a negedge.
    task automatic run_op(input vec_t v, input string tag);
        int   lat;
        logic found;
        logic bad;
        a = v.a; b = v.b; sign = v.sgn; start = 1'b1;
        #1;
        chk({tag, ":stall_req"}, 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom; b = $urandom; sign = ~sign;
        lat = 0; found = 1'b0; bad = 1'b0;
        while (!found && lat < 40) begin
            @(negedge clk);
            lat++;
            if (valid) found = 1'b1;
            else begin
                if (!busy || !stall) bad = 1'b1;
                if (lat == 5) start = 1'b1;
                if (lat == 6) start = 1'b0;
            end
        end
        start = 1'b0;
        #1;
        chk({tag, ":found"},   32'(found), 32'd1);
        chk({tag, ":latency"}, 32'(lat),   32'(v.lat));
        chk({tag, ":busy_run"}, 32'(bad),  32'd0);
        chk({tag, ":quo"},     quo,        v.q);
        chk({tag, ":rem"},     rem,        v.r);
        chk({tag, ":stall_valid"}, 32'(stall), 32'd0);
        @(negedge clk);
        chk({tag, ":valid_drop"}, 32'(valid), 32'd0);
        chk({tag, ":idle"},       32'(busy),  32'd0);
        chk({tag, ":quo_hold"},   quo,        v.q);
        chk({tag, ":rem_hold"},   rem,        v.r);
        last_q = v.q;
        last_r = v.r;
    endtask

    task automatic expect_quiet(input int n, input string name);
        logic bad;
        bad = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (valid || busy) bad = 1'b1;
        end
        chk(name, 32'(bad), 32'd0);
    endtask

    initial begin
        vec_t v93;
        resetn = 1'b0; start = 1'b0; annul = 1'b0; sign = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_quo",   quo,        32'd0);
        chk("rst_rem",   rem,        32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        vec[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
        vec[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33};
        vec[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33};
        vec[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33};
        vec[4]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33};
        vec[5]  = '{1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  1};
        vec[6]  = '{1'b1, 32'h8000_1234,  32'd0,          32'hFFFF_FFFF,  32'h8000_1234,  1};
        vec[7]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  33};
        vec[8]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  33};
        vec[9]  = '{1'b0, 32'd0,          32'd5,          32'd0,          32'd0,          33};
        vec[10] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          33};
        vec[11] = '{1'b1, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          33};

        for (int i = 0; i < 12; i++) run_op(vec[i], $sformatf("vec%0d", i));

        // annul in the 10th BUSY cycle, then a fresh 9/3
        a = 32'd100; b = 32'd7; sign = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(negedge clk);
        chk("annul_busy_pre", 32'(busy), 32'd1);
        annul = 1'b1;
        #1;
        chk("annul_busy_valid", 32'(valid), 32'd0);
        @(posedge clk); #1; annul = 1'b0;
        @(negedge clk);
        chk("annul_busy_idle", 32'(busy), 32'd0);
        chk("annul_busy_quo",  quo,       last_q);
        chk("annul_busy_rem",  rem,       last_r);
        expect_quiet(40, "annul_busy_quiet");
        v93 = '{1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33};
        run_op(v93, "after_annul");

        // annul together with start in IDLE: start not accepted
        a = 32'd5; b = 32'd1; start = 1'b1; annul = 1'b1;
        #1;
        chk("annul_start_stall", 32'(stall), 32'd0);
        @(posedge clk); #1; start = 1'b0; annul = 1'b0;
        expect_quiet(5, "annul_start_quiet");

        // annul in DONE (divide by zero reaches DONE after one edge)
        a = 32'h55; b = 32'd0; sign = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        chk("annul_done_busy", 32'(busy), 32'd1);
        annul = 1'b1;
        #1;
        chk("annul_done_valid", 32'(valid), 32'd0);
        chk("annul_done_quo",   quo,        last_q);
        @(posedge clk); #1; annul = 1'b0;
        @(negedge clk);
        chk("annul_done_idle", 32'(busy), 32'd0);
        expect_quiet(3, "annul_done_quiet");

        // asynchronous reset mid-BUSY
        a = 32'd100; b = 32'd7; sign = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("rstmid_busy",  32'(busy),  32'd0);
        chk("rstmid_valid", 32'(valid), 32'd0);
        chk("rstmid_quo",   quo,        32'd0);
        chk("rstmid_rem",   rem,        32'd0);
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        expect_quiet(40, "rstmid_quiet");
        run_op(vec[0], "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
